// File: rtl/ram_access_seq.sv
// ram_access_seq: sequences single load/store requests onto the 4-bit x 4096 RAM.
// Each access runs SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> DONE so that the
// address and write data settle before chip select and stay put after it drops.
module ram_access_seq #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_load,
  input  logic       req_store,
  input  logic [3:0] req_oprnd,
  input  logic [7:0] req_pbyte,
  input  logic [3:0] req_wdata,
  input  logic [3:0] ram_rdata,
  output logic       chips,
  output logic       enableRW,
  output logic [3:0] oprnd,
  output logic [7:0] program_byte,
  output logic [3:0] ram_wdata,
  output logic       ram_wdata_oe,
  output logic [3:0] rd_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Counter start value: ACCESS lasts exactly WAIT_CYCLES cycles (count reaches 0 on the last).
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] count;
  logic       is_store;

  // Sequencer state plus every RAM-facing output, all registered so the pins
  // change only on clock edges and the setup/hold ordering is glitch-free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= 4'd0;
      is_store     <= 1'b0;
      chips        <= 1'b0;
      enableRW     <= 1'b0;
      oprnd        <= 4'd0;
      program_byte <= 8'd0;
      ram_wdata    <= 4'd0;
      ram_wdata_oe <= 1'b0;
      rd_data      <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Store has priority when both request lines are raised together.
          if (req_store || req_load) begin
            state        <= S_SETUP;
            is_store     <= req_store;
            oprnd        <= req_oprnd;
            program_byte <= req_pbyte;
            enableRW     <= req_store;
            ram_wdata    <= req_store ? req_wdata : 4'd0;
            ram_wdata_oe <= req_store;
            busy         <= 1'b1;
          end
        end
        S_SETUP: begin
          // Address has been stable for a full cycle; assert chip select now.
          state <= S_ACCESS;
          chips <= 1'b1;
          count <= CNT_INIT;
        end
        S_ACCESS: begin
          if (count == 4'd0) begin
            state <= S_HOLD;
            chips <= 1'b0;
            if (!is_store) begin
              rd_data <= ram_rdata;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        S_HOLD: begin
          // Address and data stayed valid through HOLD; release them with done.
          state        <= S_DONE;
          done         <= 1'b1;
          enableRW     <= 1'b0;
          ram_wdata_oe <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          chips        <= 1'b0;
          enableRW     <= 1'b0;
          ram_wdata_oe <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_seq.sv
// Bench for ram_access_seq: three instances (WAIT_CYCLES 2, 1, 15), each with its
// own RAM, checked every cycle against a phase-count model plus literal expectations.
module tb_ram_access_seq;

  localparam int NI = 3;

  function automatic int wv(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic       clock = 1'b0;
  logic       reset;
  logic       req_load [NI];
  logic       req_store [NI];
  logic [3:0] req_oprnd [NI];
  logic [7:0] req_pbyte [NI];
  logic [3:0] req_wdata [NI];
  logic [3:0] ram_rdata [NI];
  logic       chips [NI];
  logic       enableRW [NI];
  logic [3:0] oprnd [NI];
  logic [7:0] program_byte [NI];
  logic [3:0] ram_wdata [NI];
  logic       ram_wdata_oe [NI];
  logic [3:0] rd_data [NI];
  logic       busy [NI];
  logic       done [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic [3:0] mem [4096];

      ram_access_seq #(.WAIT_CYCLES(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_load     (req_load[g]),
        .req_store    (req_store[g]),
        .req_oprnd    (req_oprnd[g]),
        .req_pbyte    (req_pbyte[g]),
        .req_wdata    (req_wdata[g]),
        .ram_rdata    (ram_rdata[g]),
        .chips        (chips[g]),
        .enableRW     (enableRW[g]),
        .oprnd        (oprnd[g]),
        .program_byte (program_byte[g]),
        .ram_wdata    (ram_wdata[g]),
        .ram_wdata_oe (ram_wdata_oe[g]),
        .rd_data      (rd_data[g]),
        .busy         (busy[g]),
        .done         (done[g])
      );

      assign ram_rdata[g] = mem[{oprnd[g], program_byte[g]}];

      always @(posedge clock) begin
        if (chips[g] && enableRW[g]) mem[{oprnd[g], program_byte[g]}] <= ram_wdata[g];
      end
    end
  endgenerate

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endfunction

  // Model: ph = cycle index within the current access (0 = idle).
  int         ph [NI];
  bit         m_st [NI];
  logic [11:0] m_addr [NI];
  logic [3:0] m_wd [NI];
  logic [3:0] m_rd [NI];
  logic [3:0] mmem [NI][4096];
  bit         model_ok = 0;
  int         cyc = 0;

  always @(posedge clock) begin
    model_ok = 1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        ph[i] = 0; m_st[i] = 0; m_addr[i] = 12'd0; m_wd[i] = 4'd0; m_rd[i] = 4'd0;
      end else if (ph[i] == 0) begin
        if (req_store[i] || req_load[i]) begin
          ph[i]     = 1;
          m_st[i]   = req_store[i];
          m_addr[i] = {req_oprnd[i], req_pbyte[i]};
          m_wd[i]   = req_wdata[i];
        end
      end else begin
        ph[i]++;
        if (ph[i] == wv(i) + 2) begin
          if (m_st[i]) mmem[i][m_addr[i]] = m_wd[i];
          else         m_rd[i] = mmem[i][m_addr[i]];
        end
        if (ph[i] == wv(i) + 4) ph[i] = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      for (int i = 0; i < NI; i++) begin
        int  w;
        int  p;
        bit  e_oe;
        w    = wv(i);
        p    = ph[i];
        e_oe = m_st[i] && p >= 1 && p <= w + 2;
        chk($sformatf("ctl[%0d] cyc %0d {chips,we,oe,busy,done}", i, cyc),
            {27'd0, chips[i], enableRW[i], ram_wdata_oe[i], busy[i], done[i]},
            {27'd0, (p >= 2 && p <= w + 1), e_oe, e_oe, (p != 0), (p == w + 3)});
        chk($sformatf("addr[%0d] cyc %0d", i, cyc), {20'd0, oprnd[i], program_byte[i]}, {20'd0, m_addr[i]});
        chk($sformatf("rd_data[%0d] cyc %0d", i, cyc), {28'd0, rd_data[i]}, {28'd0, m_rd[i]});
        if (e_oe) chk($sformatf("wdata[%0d] cyc %0d", i, cyc), {28'd0, ram_wdata[i]}, {28'd0, m_wd[i]});
      end
    end
  end

  task automatic run_req(input int i, input bit ld, input bit st, input logic [3:0] op,
                         input logic [7:0] pb, input logic [3:0] wd, input bit pulse,
                         output int first, output int cnt, output int dcyc, output int ndone,
                         output bit oe_seen, output bit addr_chg);
    first = -1; cnt = 0; dcyc = -1; ndone = 0; oe_seen = 0; addr_chg = 0;
    @(negedge clock);
    req_load[i] = ld; req_store[i] = st; req_oprnd[i] = op; req_pbyte[i] = pb; req_wdata[i] = wd;
    @(posedge clock);
    #1;
    req_load[i] = 1'b0; req_store[i] = 1'b0;
    for (int k = 1; k <= wv(i) + 4; k++) begin
      @(negedge clock);
      if (chips[i]) begin cnt++; if (first < 0) first = k; end
      if (done[i]) begin ndone++; if (dcyc < 0) dcyc = k; end
      if (ram_wdata_oe[i]) oe_seen = 1;
      if ({oprnd[i], program_byte[i]} != {op, pb}) addr_chg = 1;
      if (pulse && (k == 2 || k == wv(i) + 3)) begin
        req_load[i] = 1'b1; req_store[i] = 1'b1;
        req_oprnd[i] = ~op; req_pbyte[i] = ~pb; req_wdata[i] = ~wd;
      end else begin
        req_load[i] = 1'b0; req_store[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    int first, cnt, dcyc, ndone, rst_done;
    bit oe_seen, addr_chg, busy_seen;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_load[i] = 0; req_store[i] = 0; req_oprnd[i] = 0; req_pbyte[i] = 0; req_wdata[i] = 0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state", {chips[0], enableRW[0], ram_wdata_oe[0], busy[0], done[0],
                        oprnd[0], program_byte[0], rd_data[0]}, 32'd0);
    reset = 1'b1;

    // Store 0x0A5 <- 9 with W=2
    run_req(0, 0, 1, 4'h0, 8'hA5, 4'h9, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("store_first_chips", first, 2);
    chk("store_chips_cnt", cnt, 2);
    chk("store_done_cyc", dcyc, 5);
    chk("store_ndone", ndone, 1);
    chk("store_addr", {oprnd[0], program_byte[0]}, 12'h0A5);

    // Load 0x0A5 -> 9
    run_req(0, 1, 0, 4'h0, 8'hA5, 4'h0, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("load_done_cyc", dcyc, 5);
    chk("load_oe_seen", oe_seen, 0);
    chk("load_rd_data", rd_data[0], 4'h9);

    // Both requests at 0xFFF -> store of 3, then load returns 3
    run_req(0, 1, 1, 4'hF, 8'hFF, 4'h3, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("both_is_store", oe_seen, 1);
    chk("both_rd_unchanged", rd_data[0], 4'h9);
    run_req(0, 1, 0, 4'hF, 8'hFF, 4'h0, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("both_load_rd", rd_data[0], 4'h3);

    // Requests pulsed while busy are dropped
    run_req(0, 0, 1, 4'h1, 8'h23, 4'h5, 1, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("busy_ndone", ndone, 1);
    chk("busy_addr_chg", addr_chg, 0);
    @(negedge clock);
    @(negedge clock);
    chk("busy_not_queued", busy[0], 0);

    // W=1 and W=15
    run_req(1, 0, 1, 4'h0, 8'h01, 4'h7, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("w1_chips_cnt", cnt, 1);
    chk("w1_done_cyc", dcyc, 4);
    run_req(2, 0, 1, 4'h8, 8'h42, 4'hE, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("w15_chips_cnt", cnt, 15);
    chk("w15_done_cyc", dcyc, 18);
    run_req(2, 1, 0, 4'h8, 8'h42, 4'h0, 0, first, cnt, dcyc, ndone, oe_seen, addr_chg);
    chk("w15_load_rd", rd_data[2], 4'hE);

    // Reset for 3 cycles in the middle of a store
    @(negedge clock);
    req_store[0] = 1'b1; req_oprnd[0] = 4'h3; req_pbyte[0] = 8'h3C; req_wdata[0] = 4'h6;
    @(negedge clock);
    req_store[0] = 1'b0;
    @(negedge clock);
    chk("rst_pre_chips", chips[0], 1);
    reset = 1'b0;
    rst_done = 0;
    busy_seen = 0;
    @(negedge clock);
    chk("rst_all_zero", {chips[0], enableRW[0], ram_wdata_oe[0], busy[0], done[0],
                         oprnd[0], program_byte[0], rd_data[0]}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done[0]) rst_done++;
      if (busy[0]) busy_seen = 1;
    end
    chk("rst_no_done", rst_done, 0);
    chk("rst_stays_idle", busy_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
